// File: rtl/bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// bcd_display_scanner
//
// Purpose:
//   Multiplexed four-digit seven-segment driver for a common-anode display.
//   It captures four BCD digits into a snapshot register on an update
//   strobe and shows one digit per slot at a programmable scan rate. Every
//   slot starts with one dark cycle to stop ghosting. Any digit above 9 in
//   the snapshot is flagged. All outputs are registered.
//
// Ports:
//   clk         in   1  system clock, rising edge
//   reset_n     in   1  asynchronous, active-low reset
//   digit_001   in   4  units BCD digit
//   digit_010   in   4  tens BCD digit
//   digit_100   in   4  hundreds BCD digit
//   digit_1000  in   4  thousands BCD digit
//   update      in   1  load all four digits into the snapshot this edge
//   seg         out  7  {g,f,e,d,c,b,a}, active-low
//   an          out  4  digit enables, active-low, an[0] = units
//   digit_sel   out  2  index of the slot being shown (0 = units)
//   bcd_err     out  1  high while any snapshot digit is greater than 9
//
// Parameters:
//   SCAN_DIV    clk cycles per digit slot (must be at least 2)
//
// Build options:
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are blanked
//                          (units is never blanked).
// ---------------------------------------------------------------------------
module bcd_display_scanner #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] digit_001,
  input  logic [3:0] digit_010,
  input  logic [3:0] digit_100,
  input  logic [3:0] digit_1000,
  input  logic       update,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic [1:0] digit_sel,
  output logic       bcd_err
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST_COUNT = PW'(SCAN_DIV - 1);

  logic [PW-1:0] count;
  logic [1:0]    index;
  logic [3:0]    snap [4];

  logic [3:0]    cur_digit;
  logic [3:0]    blank;
  logic [6:0]    seg_next;
  logic [3:0]    an_next;
  logic          err_next;

  // Active-low segment pattern; non-BCD codes show a dash (only g lit).
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  // Prescaler and slot index: the index advances only when the prescaler wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      index <= 2'd0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
      index <= index + 2'd1;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Snapshot: the display never reads the digit inputs directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) snap[i] <= 4'd0;
    end else if (update) begin
      snap[0] <= digit_001;
      snap[1] <= digit_010;
      snap[2] <= digit_100;
      snap[3] <= digit_1000;
    end
  end

  // Blanking chains downward from thousands; a non-BCD digit counts as non-zero.
  always_comb begin
    blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    blank[3] = (snap[3] == 4'd0);
    blank[2] = blank[3] && (snap[2] == 4'd0);
    blank[1] = blank[2] && (snap[1] == 4'd0);
`endif
  end

  // Next-state for the registered outputs, all taken from the current state.
  always_comb begin
    cur_digit = snap[index];
    seg_next  = decode(cur_digit);
    if ((count == '0) || blank[index]) begin
      an_next = 4'hF;
    end else begin
      an_next = ~(4'b0001 << index);
    end
    err_next = (snap[0] > 4'd9) || (snap[1] > 4'd9) ||
               (snap[2] > 4'd9) || (snap[3] > 4'd9);
  end

  // Output registers: one cycle behind the prescaler, index and snapshot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg       <= 7'h7F;
      an        <= 4'hF;
      digit_sel <= 2'd0;
      bcd_err   <= 1'b0;
    end else begin
      seg       <= seg_next;
      an        <= an_next;
      digit_sel <= index;
      bcd_err   <= err_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_scanner
//
// Self-checking bench for bcd_display_scanner with SCAN_DIV = 4. A reference
// model tracks the number of clock edges since reset and the snapshot
// contents. Expected outputs come from frame arithmetic: the position in the
// frame, the slot, and the count within the slot. Blanking in the model
// follows LEADING_ZERO_BLANK_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_bcd_display_scanner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] digit_001 = 4'd0;
  logic [3:0] digit_010 = 4'd0;
  logic [3:0] digit_100 = 4'd0;
  logic [3:0] digit_1000 = 4'd0;
  logic       update = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] digit_sel;
  logic       bcd_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int         m_edges;
  logic [3:0] m_snap [4];
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic [1:0] exp_sel;
  logic       exp_err;
  int         exp_slot;
  int         exp_cnt;

  bcd_display_scanner #(.SCAN_DIV(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .digit_001  (digit_001),
    .digit_010  (digit_010),
    .digit_100  (digit_100),
    .digit_1000 (digit_1000),
    .update     (update),
    .seg        (seg),
    .an         (an),
    .digit_sel  (digit_sel),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] table_v [10];
    table_v = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 4'd9) return 7'h3F;
    return table_v[d];
  endfunction

  function automatic bit slot_blanked(input int slot);
    bit all_zero;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot == 0) return 1'b0;
    all_zero = 1'b1;
    for (int j = slot; j < 4; j++) if (m_snap[j] != 4'd0) all_zero = 1'b0;
    return all_zero;
`else
    all_zero = 1'b0;
    return all_zero;
`endif
  endfunction

  task automatic model_reset();
    m_edges = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
  endtask

  // Drives inputs for one edge, advances the model, and returns #1 after the edge.
  task automatic tick(input logic upd, input logic [3:0] d0, input logic [3:0] d1,
                      input logic [3:0] d2, input logic [3:0] d3);
    int p;
    update     = upd;
    digit_001  = d0;
    digit_010  = d1;
    digit_100  = d2;
    digit_1000 = d3;
    @(posedge clk);
    p        = m_edges % (4 * D);
    exp_slot = p / D;
    exp_cnt  = p % D;
    exp_seg  = seg_of(m_snap[exp_slot]);
    exp_sel  = 2'(exp_slot);
    exp_err  = 1'b0;
    for (int i = 0; i < 4; i++) if (m_snap[i] > 4'd9) exp_err = 1'b1;
    if (exp_cnt == 0 || slot_blanked(exp_slot)) exp_an = 4'hF;
    else exp_an = ~(4'b0001 << exp_slot);
    if (upd) begin
      m_snap[0] = d0;
      m_snap[1] = d1;
      m_snap[2] = d2;
      m_snap[3] = d3;
    end
    m_edges++;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({seg, an, digit_sel, bcd_err} !== {7'h7F, 4'hF, 2'd0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL reset: seg=%h an=%b sel=%0d err=%b, want seg=7f an=1111 sel=0 err=0",
               seg, an, digit_sel, bcd_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_idle_frame();
    for (int i = 0; i < 4 * D; i++) begin
      tick(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
      n_vec++;
      if ({seg, an, digit_sel, bcd_err} !== {exp_seg, exp_an, exp_sel, exp_err}) begin
        n_err++;
        $display("[TB] FAIL idle_frame[%0d]: got seg=%h an=%b sel=%0d err=%b, want seg=%h an=%b sel=%0d err=%b",
                 i, seg, an, digit_sel, bcd_err, exp_seg, exp_an, exp_sel, exp_err);
      end
    end
  endtask

  task automatic test_load(input string name, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3, input int cycles);
    tick(1'b1, d0, d1, d2, d3);
    for (int i = 0; i < cycles; i++) begin
      tick(1'b0, 4'(i), 4'(i + 3), 4'(i + 7), 4'(i + 11));
      n_vec++;
      if ({seg, an, digit_sel, bcd_err} !== {exp_seg, exp_an, exp_sel, exp_err}) begin
        n_err++;
        $display("[TB] FAIL %s[%0d]: got seg=%h an=%b sel=%0d err=%b, want seg=%h an=%b sel=%0d err=%b",
                 name, i, seg, an, digit_sel, bcd_err, exp_seg, exp_an, exp_sel, exp_err);
      end
    end
  endtask

  task automatic test_held_update();
    for (int i = 0; i < 8 * D; i++) begin
      tick(1'b1, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
           4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
      n_vec++;
      if ({seg, an, digit_sel, bcd_err} !== {exp_seg, exp_an, exp_sel, exp_err}) begin
        n_err++;
        $display("[TB] FAIL held_update[%0d]: got seg=%h an=%b sel=%0d err=%b, want seg=%h an=%b sel=%0d err=%b",
                 i, seg, an, digit_sel, bcd_err, exp_seg, exp_an, exp_sel, exp_err);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r [4];
    for (int i = 0; i < 400; i++) begin
      for (int j = 0; j < 4; j++) begin
        r[j] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      tick(($urandom_range(0, 9) == 0), r[0], r[1], r[2], r[3]);
      n_vec++;
      if ({seg, an, digit_sel, bcd_err} !== {exp_seg, exp_an, exp_sel, exp_err}) begin
        n_err++;
        $display("[TB] FAIL random[%0d]: got seg=%h an=%b sel=%0d err=%b, want seg=%h an=%b sel=%0d err=%b",
                 i, seg, an, digit_sel, bcd_err, exp_seg, exp_an, exp_sel, exp_err);
      end
    end
  endtask

  task automatic test_update_at_wrap();
    // Run until the next edge is the last count of a slot, then update on it.
    for (int i = 0; i < D && (m_edges % D) != D - 1; i++) tick(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    tick(1'b1, 4'd6, 4'd7, 4'd8, 4'd9);
    for (int i = 0; i < 2 * D; i++) begin
      tick(1'b0, 4'd1, 4'd1, 4'd1, 4'd1);
      n_vec++;
      if ({seg, an, digit_sel, bcd_err} !== {exp_seg, exp_an, exp_sel, exp_err}) begin
        n_err++;
        $display("[TB] FAIL update_at_wrap[%0d]: got seg=%h an=%b sel=%0d err=%b, want seg=%h an=%b sel=%0d err=%b",
                 i, seg, an, digit_sel, bcd_err, exp_seg, exp_an, exp_sel, exp_err);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    tick(1'b1, 4'd4, 4'd3, 4'd2, 4'd1);
    for (int i = 0; i < 4 * D && !(exp_slot == 2 && exp_cnt == 2); i++) begin
      tick(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    end
    n_vec++;
    if (!(exp_slot == 2 && exp_cnt == 2) || digit_sel !== 2'd2) begin
      n_err++;
      $display("[TB] FAIL mid_frame_reach: sel=%0d, want sel=2 before reset", digit_sel);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({seg, an, digit_sel, bcd_err} !== {7'h7F, 4'hF, 2'd0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL mid_frame_reset: seg=%h an=%b sel=%0d err=%b, want seg=7f an=1111 sel=0 err=0",
               seg, an, digit_sel, bcd_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * D; i++) begin
      tick(1'b0, 4'd9, 4'd9, 4'd9, 4'd9);
      n_vec++;
      if ({seg, an, digit_sel, bcd_err} !== {exp_seg, exp_an, exp_sel, exp_err}) begin
        n_err++;
        $display("[TB] FAIL after_reset[%0d]: got seg=%h an=%b sel=%0d err=%b, want seg=%h an=%b sel=%0d err=%b",
                 i, seg, an, digit_sel, bcd_err, exp_seg, exp_an, exp_sel, exp_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_frame();
    test_load("count_1234", 4'd4, 4'd3, 4'd2, 4'd1, 4 * D);
    test_load("blank_0050", 4'd0, 4'd5, 4'd0, 4'd0, 4 * D);
    test_load("err_set", 4'hB, 4'd0, 4'd0, 4'd0, 4 * D);
    test_load("err_clear", 4'd7, 4'd0, 4'd0, 4'd0, 4 * D);
    test_held_update();
    test_update_at_wrap();
    test_random();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_display_scanner.md
# bcd_display_scanner

Multiplexed four-digit seven-segment driver that consumes the four BCD digits produced by the decade counter chain and drives a common-anode display: one segment bus plus four digit enables. It captures the digits into a snapshot register on an update strobe, time-multiplexes them at a programmable scan rate, blanks non-significant leading zeros, and flags any non-BCD digit. All outputs are registered.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; legal range ≥ 2; prescaler width $clog2(SCAN_DIV).
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- digit_001  in  4  units BCD digit.
- digit_010  in  4  tens BCD digit.
- digit_100  in  4  hundreds BCD digit.
- digit_1000  in  4  thousands BCD digit.
- update  in  1  when high at a clk edge, all four digits load into the snapshot; if held high, the snapshot tracks the inputs each cycle.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low; an[0] = units … an[3] = thousands.
- digit_sel  out  2  index of the slot currently being shown (0 = units).
- bcd_err  out  1  high while any snapshot digit is > 9.

## Operation
- Prescaler counts 0..SCAN_DIV-1 and wraps. On wrap, the slot index advances 0→1→2→3→0.
- Snapshot: four 4-bit registers. They are zero after reset and load on update. Display content changes only via the snapshot, never directly from the inputs.
- Decode (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - 10..15 = 3F (segment g only, shown as a dash).
- Anti-ghosting: on prescaler count 0 of every slot, an = 4'hF. On the remaining counts, an = ~(1<<index) unless that slot is blanked.
- seg always carries the decode of the current slot's digit, including during blanked counts.
- bcd_err = OR over the four snapshot digits of (digit > 9). It is registered and updates the cycle after the snapshot changes.
- Reset values: prescaler 0, index 0, snapshot 0, seg 7'h7F, an 4'hF, digit_sel 0, bcd_err 0.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). Scanning restarts at slot 0, count 0.

## Timing
- Output latency: seg, an and digit_sel are registered from the current prescaler, index and snapshot, so they lag the state by 1 cycle.
- Snapshot latency: an update at edge N loads the snapshot at N. The new pattern appears on seg at edge N+1, in whichever slot is active.
- Slot length is exactly SCAN_DIV cycles; a full frame is 4×SCAN_DIV cycles. an is active for SCAN_DIV-1 of every SCAN_DIV cycles.
- digit_sel changes on the same edge as the slot's first (dark) cycle.
- update in the same cycle as a slot wrap: the new slot shows the new snapshot value one cycle later. No cycle shows a mix of old and new digits.

## Configuration
- LEADING_ZERO_BLANK_EN defined: a slot is blanked (its an bit stays 1 for the whole slot) when that digit and every higher digit are zero.
  - Thousands blanks if it is 0; hundreds if it and thousands are 0; tens likewise.
  - Units is never blanked.
  - A digit > 9 counts as non-zero.
- LEADING_ZERO_BLANK_EN undefined: no slot is blanked; all four digits are always lit, including leading zeros.

## Test plan
- Reset, SCAN_DIV=4, no update → 16-cycle frame. seg=40 in every slot. With blanking defined, only an=1110 pulses (3 of 4 cycles); without it, an walks 1110→1101→1011→0111, each preceded by one 1111 cycle.
- update one cycle with 1000=1, 100=2, 10=3, 001=4 → over the next frame seg=19,30,24,79 for slots 0..3. an is active in all slots; bcd_err=0.
- Blanking defined, snapshot 0,0,5,0 (1000..001) → slots 2 and 3 hold an=1111 for the whole slot; slot 1 shows 12 and slot 0 shows 40.
- Snapshot 001=4'hB → seg=3F in slot 0; bcd_err rises one cycle after the snapshot load. Loading a valid value clears bcd_err one cycle after the reload.
- update held high while the inputs change every cycle → seg follows the current slot's input with 2-cycle latency.
- reset_n asserted mid-slot 2 → seg=7F, an=1111, digit_sel=0 immediately, without waiting for a clk edge. After release, slot 0 lasts a full SCAN_DIV cycles.
